// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: host-link receiver control, status and FIFO handshake bundle
interface uart_rx_cfg_if #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
);
    logic [DIV_WIDTH-1:0]         i_div;
    logic                         i_rx;
    logic                         i_ready;
    logic                         i_clr_ovr;
    logic                         o_valid;
    logic [DATA_BITS-1:0]         o_data;
    logic                         o_perr;
    logic                         o_ferr;
    logic                         o_brk;
    logic                         o_overrun;
    logic [$clog2(FIFO_DEPTH):0]  o_level;
    logic                         o_busy;

    modport slave (
        input  i_div, i_rx, i_ready, i_clr_ovr,
        output o_valid, o_data, o_perr, o_ferr, o_brk, o_overrun, o_level, o_busy
    );

    modport master (
        output i_div, i_rx, i_ready, i_clr_ovr,
        input  o_valid, o_data, o_perr, o_ferr, o_brk, o_overrun, o_level, o_busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with error flags, break detect and show-ahead FIFO
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    uart_rx_cfg_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_BITS + 3;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRKWAIT} state_t;

    state_t               state, state_n;
    logic                 s1, rxs;
    logic [DIV_WIDTH-1:0] cnt, div_l;
    logic [3:0]           bitn;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr;
    logic                 push;
    logic [EW-1:0]        push_w;
    logic                 tick, last_data, last_stop, stop_bad, par_bit, is_brk;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          level;
    logic [EW-1:0]        last, head;
    logic                 full, pop, wr, drop, ovr;

    assign tick      = cnt == div_l;
    assign last_data = bitn == 4'(DATA_BITS - 1);
    assign last_stop = bitn == 4'(STOP_BITS - 1);
    assign stop_bad  = ferr | ~rxs;
    assign par_bit   = (PARITY == 1) ? ~^shreg : ^shreg;
    assign is_brk    = stop_bad && shreg == '0;

    // State register
    always_ff @(posedge i_clk) begin
        state <= i_rst ? IDLE : state_n;
    end

    // Frame sequencing; break frames park in BRKWAIT until the line goes idle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rxs ? IDLE : START;
            START:   state_n = tick ? (rxs ? IDLE : DATA) : START;
            DATA:    state_n = (tick && last_data) ? ((PARITY != 0) ? PAR : STOP) : DATA;
            PAR:     state_n = tick ? STOP : PAR;
            STOP:    state_n = (tick && last_stop) ? (is_brk ? BRKWAIT : IDLE) : STOP;
            BRKWAIT: state_n = rxs ? IDLE : BRKWAIT;
            default: state_n = IDLE;
        endcase
    end

    // Synchroniser, bit timer, shifter and error accumulation; raises push after the last stop sample
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1     <= 1'b1;
            rxs    <= 1'b1;
            cnt    <= '0;
            div_l  <= '0;
            bitn   <= '0;
            shreg  <= '0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            push   <= 1'b0;
            push_w <= '0;
        end else begin
            s1   <= bus.i_rx;
            rxs  <= s1;
            push <= 1'b0;
            if (state == IDLE) begin
                div_l <= bus.i_div;
                cnt   <= bus.i_div >> 1;
                bitn  <= '0;
                perr  <= 1'b0;
                ferr  <= 1'b0;
            end else if (state != BRKWAIT) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick && state == DATA) begin
                    shreg <= {rxs, shreg[DATA_BITS-1:1]};
                    bitn  <= last_data ? '0 : bitn + 1'b1;
                end
                if (tick && state == PAR)
                    perr <= rxs != par_bit;
                if (tick && state == STOP) begin
                    ferr <= stop_bad;
                    bitn <= bitn + 1'b1;
                    if (last_stop) begin
                        push   <= 1'b1;
                        push_w <= {is_brk, stop_bad, perr, shreg};
                    end
                end
            end
        end
    end

    assign full = level == LW'(FIFO_DEPTH);
    assign pop  = bus.o_valid && bus.i_ready;
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (wr && !i_rst)
            mem[wr_ptr] <= push_w;
    end

    // FIFO pointers, occupancy, sticky overrun and the held head after a pop
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovr    <= 1'b0;
            last   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + LW'(wr) - LW'(pop);
            ovr    <= drop | (ovr & ~bus.i_clr_ovr);
            if (pop)
                last <= mem[rd_ptr];
        end
    end

    assign head          = bus.o_valid ? mem[rd_ptr] : last;
    assign bus.o_valid   = level != '0;
    assign bus.o_data    = head[DATA_BITS-1:0];
    assign bus.o_perr    = head[DATA_BITS];
    assign bus.o_ferr    = head[DATA_BITS+1];
    assign bus.o_brk     = head[DATA_BITS+2];
    assign bus.o_overrun = ovr;
    assign bus.o_level   = level;
    assign bus.o_busy    = state != IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of framing, parity, break, FIFO overrun, reset and divisor changes
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    uart_rx_cfg_if #(.DATA_BITS(8), .DIV_WIDTH(16), .FIFO_DEPTH(4)) b0 ();
    uart_rx_cfg_if #(.DATA_BITS(8), .DIV_WIDTH(16), .FIFO_DEPTH(4)) b1 ();

    uart_rx_cfg dut0 (.i_clk(clk), .i_rst(rst), .bus(b0));
    uart_rx_cfg #(.PARITY(2)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int inst, input int n, input logic [15:0] bits, input int bc);
        for (int k = 0; k < n; k++) begin
            if (inst == 0) b0.i_rx = bits[k];
            else b1.i_rx = bits[k];
            cyc(bc);
        end
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stp);
        return {6'h00, stp, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8e1(input logic [7:0] d, input logic p);
        return {5'h00, 1'b1, p, d, 1'b0};
    endfunction

    task automatic pop0;
        b0.i_ready = 1'b1;
        cyc(1);
        b0.i_ready = 1'b0;
    endtask

    task automatic pop1;
        b1.i_ready = 1'b1;
        cyc(1);
        b1.i_ready = 1'b0;
    endtask

    initial begin
        b0.i_div = 16'd15; b0.i_rx = 1'b1; b0.i_ready = 1'b0; b0.i_clr_ovr = 1'b0;
        b1.i_div = 16'd15; b1.i_rx = 1'b1; b1.i_ready = 1'b0; b1.i_clr_ovr = 1'b0;
        cyc(4);
        chk("rst_valid", b0.o_valid, 0);
        chk("rst_level", b0.o_level, 0);
        chk("rst_busy", b0.o_busy, 0);
        chk("rst_ovr", b0.o_overrun, 0);
        chk("rst_data", b0.o_data, 0);
        rst = 1'b0;
        cyc(2);

        b0.i_ready = 1'b1;
        fork
            begin
                send(0, 10, f8n1(8'hA5, 1'b1), 16);
                send(0, 10, f8n1(8'h3C, 1'b1), 16);
            end
            begin
                cyc(156);
                chk("a5_before", b0.o_valid, 0);
                cyc(1);
                chk("a5_valid", b0.o_valid, 1);
                chk("a5_data", b0.o_data, 8'hA5);
                chk("a5_flags", {b0.o_perr, b0.o_ferr, b0.o_brk}, 3'b000);
                cyc(159);
                chk("3c_before", b0.o_valid, 0);
                cyc(1);
                chk("3c_valid", b0.o_valid, 1);
                chk("3c_data", b0.o_data, 8'h3C);
                chk("3c_flags", {b0.o_perr, b0.o_ferr, b0.o_brk}, 3'b000);
            end
        join
        chk("b2b_level", b0.o_level, 0);
        b0.i_ready = 1'b0;

        send(1, 11, f8e1(8'h01, 1'b0), 16);
        send(1, 11, f8e1(8'h01, 1'b1), 16);
        chk("par_level", b1.o_level, 2);
        chk("par_bad_data", b1.o_data, 8'h01);
        chk("par_bad_perr", b1.o_perr, 1);
        chk("par_bad_ferr", b1.o_ferr, 0);
        pop1;
        chk("par_ok_data", b1.o_data, 8'h01);
        chk("par_ok_perr", b1.o_perr, 0);
        pop1;
        chk("par_empty", b1.o_valid, 0);

        send(0, 10, f8n1(8'h55, 1'b0), 16);
        b0.i_rx = 1'b1;
        cyc(30);
        chk("fe_level", b0.o_level, 1);
        chk("fe_data", b0.o_data, 8'h55);
        chk("fe_flags", {b0.o_perr, b0.o_ferr, b0.o_brk}, 3'b010);
        pop0;

        b0.i_rx = 1'b0;
        cyc(480);
        chk("brk_busy_low", b0.o_busy, 1);
        chk("brk_level_low", b0.o_level, 1);
        b0.i_rx = 1'b1;
        cyc(6);
        chk("brk_busy_idle", b0.o_busy, 0);
        chk("brk_data", b0.o_data, 8'h00);
        chk("brk_flags", {b0.o_perr, b0.o_ferr, b0.o_brk}, 3'b011);
        cyc(100);
        chk("brk_once", b0.o_level, 1);
        pop0;

        for (int i = 0; i < 5; i++)
            send(0, 10, f8n1(8'(8'h10 + i), 1'b1), 16);
        cyc(4);
        chk("ovr_level", b0.o_level, 4);
        chk("ovr_flag", b0.o_overrun, 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovr_pop_data", b0.o_data, 8'h10 + i);
            pop0;
        end
        chk("ovr_empty", b0.o_valid, 0);
        chk("ovr_hold_data", b0.o_data, 8'h13);
        chk("ovr_sticky", b0.o_overrun, 1);
        b0.i_clr_ovr = 1'b1;
        cyc(1);
        b0.i_clr_ovr = 1'b0;
        chk("ovr_clear", b0.o_overrun, 0);

        b0.i_rx = 1'b0;
        cyc(4);
        b0.i_rx = 1'b1;
        cyc(4);
        chk("glitch_busy", b0.o_busy, 1);
        cyc(20);
        chk("glitch_idle", b0.o_busy, 0);
        chk("glitch_nopush", b0.o_level, 0);

        b0.i_rx = 1'b0;
        cyc(16);
        b0.i_rx = 1'b1;
        cyc(24);
        chk("mid_busy", b0.o_busy, 1);
        rst = 1'b1;
        cyc(1);
        chk("mrst_busy", b0.o_busy, 0);
        chk("mrst_valid", b0.o_valid, 0);
        chk("mrst_data", b0.o_data, 0);
        chk("mrst_flags", {b0.o_perr, b0.o_ferr, b0.o_brk, b0.o_overrun}, 4'b0000);
        rst = 1'b0;
        cyc(200);
        chk("mrst_nopush", b0.o_level, 0);
        send(0, 10, f8n1(8'h12, 1'b1), 16);
        chk("post_rst_level", b0.o_level, 1);
        chk("post_rst_data", b0.o_data, 8'h12);
        pop0;

        fork
            send(0, 10, f8n1(8'h5A, 1'b1), 16);
            begin
                cyc(40);
                b0.i_div = 16'd31;
            end
        join
        send(0, 10, f8n1(8'hC3, 1'b1), 32);
        cyc(4);
        chk("div_level", b0.o_level, 2);
        chk("div_old_data", b0.o_data, 8'h5A);
        chk("div_old_ferr", b0.o_ferr, 0);
        pop0;
        chk("div_new_data", b0.o_data, 8'hC3);
        chk("div_new_ferr", b0.o_ferr, 0);
        pop0;
        chk("div_empty", b0.o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
